// File: rtl/pipe_trace_checker.sv
// Cycle-stamped expected-value checker for core debug taps: replays up to DEPTH
// stored entries against NCH observed channels and keeps pass/fail statistics.
module pipe_trace_checker #(
  parameter int NCH   = 3,
  parameter int W     = 34,
  parameter int DEPTH = 16,
  parameter int CW    = 16,
  parameter int IW    = $clog2(DEPTH),
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_we,
  input  logic [IW-1:0]       load_addr,
  input  logic [CW-1:0]       load_stamp,
  input  logic [NCH*W-1:0]    load_exp,
  input  logic [NCH*W-1:0]    load_mask,
  input  logic [CNTW-1:0]     n_entries,
  input  logic                start,
  input  logic [NCH*W-1:0]    obs,
  output logic                busy,
  output logic                done,
  output logic                chk_valid,
  output logic                chk_pass,
  output logic [IW-1:0]       chk_idx,
  output logic [NCH-1:0]      chk_fail_mask,
  output logic [CNTW-1:0]     pass_cnt,
  output logic [CNTW-1:0]     fail_cnt,
  output logic                first_fail_valid,
  output logic [IW-1:0]       first_fail_idx,
  output logic [NCH-1:0]      first_fail_mask,
  output logic                order_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       stamp_mem [DEPTH];
  logic [NCH*W-1:0]    exp_mem   [DEPTH];
  logic [NCH*W-1:0]    mask_mem  [DEPTH];

  logic [CW-1:0]       cycle_cnt;
  logic [IW-1:0]       idx;
  logic [CNTW-1:0]     n_lat;

  logic [CW-1:0]       cur_stamp;
  logic [NCH*W-1:0]    cur_diff;
  logic [NCH-1:0]      cmp_fail;
  logic                hit;
  logic                miss;
  logic [NCH-1:0]      eval_mask;
  logic                eval_pass;
  logic                last_entry;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Entry memory has no reset so a loaded trace survives rst for re-runs.
  always_ff @(posedge clk) begin
    if (load_we && state != RUN) begin
      stamp_mem[load_addr] <= load_stamp;
      exp_mem[load_addr]   <= load_exp;
      mask_mem[load_addr]  <= load_mask;
    end
  end

  always_comb begin
    cur_stamp = stamp_mem[idx];
    cur_diff  = (obs ^ exp_mem[idx]) & mask_mem[idx];
    cmp_fail  = '0;
    for (int c = 0; c < NCH; c++) begin
      cmp_fail[c] = |cur_diff[c*W +: W];
    end
    hit        = (cycle_cnt == cur_stamp);
    miss       = (cycle_cnt > cur_stamp);
    eval_mask  = miss ? {NCH{1'b1}} : cmp_fail;
    eval_pass  = hit && (cmp_fail == '0);
    last_entry = ({{(CNTW-IW){1'b0}}, idx} == n_lat - CNTW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cycle_cnt        <= '0;
      idx              <= '0;
      n_lat            <= '0;
      chk_valid        <= 1'b0;
      chk_pass         <= 1'b0;
      chk_idx          <= '0;
      chk_fail_mask    <= '0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_mask  <= '0;
      order_err        <= 1'b0;
    end else begin
      chk_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cycle_cnt        <= '0;
            idx              <= '0;
            n_lat            <= n_entries;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_mask  <= '0;
            order_err        <= 1'b0;
            state            <= (n_entries == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (cycle_cnt != {CW{1'b1}}) cycle_cnt <= cycle_cnt + CW'(1);
          // A stamp already behind the counter still consumes the entry, as a miss.
          if (hit || miss) begin
            chk_valid     <= 1'b1;
            chk_pass      <= eval_pass;
            chk_idx       <= idx;
            chk_fail_mask <= eval_mask;
            if (eval_pass) begin
              pass_cnt <= pass_cnt + CNTW'(1);
            end else begin
              fail_cnt <= fail_cnt + CNTW'(1);
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_idx   <= idx;
                first_fail_mask  <= eval_mask;
              end
            end
            if (miss) order_err <= 1'b1;
            idx <= idx + IW'(1);
            if (last_entry) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_trace_checker.sv
// Randomised bench for pipe_trace_checker: an entry-by-entry reference model
// predicts every chk_valid event, the final counters and the sticky flags.
module tb_pipe_trace_checker;
  localparam int NCH    = 3;
  localparam int W      = 34;
  localparam int DEPTH  = 16;
  localparam int CW     = 16;
  localparam int IW     = $clog2(DEPTH);
  localparam int CNTW   = $clog2(DEPTH + 1);
  localparam int TW     = NCH * W;
  localparam int NCYC   = 128;
  localparam int BUDGET = 120;
  localparam int EW     = CW + IW + 1 + NCH;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_we;
  logic [IW-1:0]     load_addr;
  logic [CW-1:0]     load_stamp;
  logic [TW-1:0]     load_exp;
  logic [TW-1:0]     load_mask;
  logic [CNTW-1:0]   n_entries;
  logic              start;
  logic [TW-1:0]     obs;
  logic              busy;
  logic              done;
  logic              chk_valid;
  logic              chk_pass;
  logic [IW-1:0]     chk_idx;
  logic [NCH-1:0]    chk_fail_mask;
  logic [CNTW-1:0]   pass_cnt;
  logic [CNTW-1:0]   fail_cnt;
  logic              first_fail_valid;
  logic [IW-1:0]     first_fail_idx;
  logic [NCH-1:0]    first_fail_mask;
  logic              order_err;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pipe_trace_checker #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
    .load_stamp(load_stamp), .load_exp(load_exp), .load_mask(load_mask),
    .n_entries(n_entries), .start(start), .obs(obs), .busy(busy), .done(done),
    .chk_valid(chk_valid), .chk_pass(chk_pass), .chk_idx(chk_idx),
    .chk_fail_mask(chk_fail_mask), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
    .first_fail_mask(first_fail_mask), .order_err(order_err)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model state ----------------
  logic [CW-1:0]  m_stamp [DEPTH];
  logic [TW-1:0]  m_exp   [DEPTH];
  logic [TW-1:0]  m_mask  [DEPTH];
  logic [TW-1:0]  obs_seq [NCYC];
  logic [EW-1:0]  exp_q[$];
  int             m_pass, m_fail, m_last_cyc;
  logic           m_ff_v, m_oerr;
  logic [IW-1:0]  m_ff_idx;
  logic [NCH-1:0] m_ff_mask;

  logic [TW-1:0] e0, e1;

  function automatic logic [TW-1:0] rand_vec();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[TW-1:0];
  endfunction

  function automatic logic [NCH-1:0] chan_diff(input logic [TW-1:0] o, e, m);
    logic [TW-1:0] d;
    logic [NCH-1:0] f;
    d = (o ^ e) & m;
    for (int c = 0; c < NCH; c++) f[c] = (d[c*W +: W] != '0);
    return f;
  endfunction

  // Walks entries in order: an entry is seen at its stamp if the counter has
  // not passed it yet, otherwise at the next free cycle as a miss.
  task automatic build_model(input int n);
    int t;
    int ev;
    logic [NCH-1:0] fm;
    t = 0; exp_q.delete();
    m_pass = 0; m_fail = 0; m_last_cyc = -1;
    m_ff_v = 0; m_ff_idx = '0; m_ff_mask = '0; m_oerr = 0;
    for (int i = 0; i < n; i++) begin
      if (int'(m_stamp[i]) >= t) begin
        ev = int'(m_stamp[i]);
        fm = chan_diff(obs_seq[ev], m_exp[i], m_mask[i]);
      end else begin
        ev = t;
        fm = '1;
        m_oerr = 1;
      end
      exp_q.push_back({CW'(ev), IW'(i), (fm == '0), fm});
      if (fm == '0) m_pass++;
      else begin
        m_fail++;
        if (!m_ff_v) begin m_ff_v = 1; m_ff_idx = IW'(i); m_ff_mask = fm; end
      end
      t = ev + 1;
      m_last_cyc = ev;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_entry(input int a, input logic [CW-1:0] s, input logic [TW-1:0] e, m);
    @(negedge clk);
    load_we = 1; load_addr = IW'(a); load_stamp = s; load_exp = e; load_mask = m;
    m_stamp[a] = s; m_exp[a] = e; m_mask[a] = m;
    @(negedge clk);
    load_we = 0;
  endtask

  task automatic fill_obs();
    for (int k = 0; k < NCYC; k++) obs_seq[k] = rand_vec();
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({busy, done, chk_valid, chk_pass, chk_idx, chk_fail_mask, pass_cnt, fail_cnt,
         first_fail_valid, first_fail_idx, first_fail_mask, order_err} !== '0) begin
      errors++;
      $display("FAIL %s outputs not zero: busy=%b done=%b valid=%b pass=%0d fail=%0d ff=%b oerr=%b",
               name, busy, done, chk_valid, pass_cnt, fail_cnt, first_fail_valid, order_err);
    end
  endtask

  // ---------------- scoreboard run ----------------
  task automatic run_entries(input int n, input bit ld_with_start, input bit poke,
                             input string name, output int done_k);
    logic [EW-1:0] ev;
    logic [EW-1:0] head;
    build_model(n);
    @(negedge clk);
    start = 1; n_entries = CNTW'(n);
    if (ld_with_start) begin
      load_we = 1; load_addr = IW'(n - 1); load_stamp = m_stamp[n-1];
      load_exp = m_exp[n-1]; load_mask = m_mask[n-1];
    end
    done_k = -1;
    for (int k = 0; k < BUDGET && done_k < 0; k++) begin
      @(negedge clk);
      obs = obs_seq[k];
      if (poke && k == 1) begin
        start = 1; n_entries = CNTW'(1);
        load_we = 1; load_addr = '0; load_stamp = CW'(1); load_exp = rand_vec(); load_mask = '1;
      end else begin
        start = 0; load_we = 0; n_entries = CNTW'(n);
      end
      checks++;
      if ({busy, done} !== ((k <= m_last_cyc) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL %s state cycle %0d: busy=%b done=%b want busy=%b", name, k, busy, done,
                 (k <= m_last_cyc));
      end
      if (chk_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s spurious chk_valid cycle %0d idx=%0d", name, k, chk_idx);
        end else begin
          ev = exp_q.pop_front();
          if (k != int'(ev[EW-1 -: CW]) + 1) begin
            errors++;
            $display("FAIL %s chk_timing got cycle %0d want %0d", name, k, int'(ev[EW-1 -: CW]) + 1);
          end
          checks++;
          if ({chk_idx, chk_pass, chk_fail_mask} !== ev[IW+NCH:0]) begin
            errors++;
            $display("FAIL %s chk result cycle %0d: idx=%0d pass=%b mask=%b want %h",
                     name, k, chk_idx, chk_pass, chk_fail_mask, ev[IW+NCH:0]);
          end
        end
      end else if (exp_q.size() > 0) begin
        head = exp_q[0];
        if (int'(head[EW-1 -: CW]) + 1 == k) begin
          checks++; errors++;
          $display("FAIL %s missing chk_valid cycle %0d want idx %0d", name, k, head[IW+NCH:NCH+1]);
          void'(exp_q.pop_front());
        end
      end
      if (done === 1'b1) done_k = k;
    end
    start = 0; load_we = 0;
    checks++;
    if (done_k < 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s run end: done_cycle=%0d pending=%0d want done and 0 pending",
               name, done_k, exp_q.size());
    end
    checks++;
    if (pass_cnt !== CNTW'(m_pass) || fail_cnt !== CNTW'(m_fail)) begin
      errors++;
      $display("FAIL %s counters pass=%0d fail=%0d want %0d %0d", name, pass_cnt, fail_cnt, m_pass, m_fail);
    end
    checks++;
    if ({first_fail_valid, first_fail_idx, first_fail_mask, order_err} !==
        {m_ff_v, m_ff_idx, m_ff_mask, m_oerr}) begin
      errors++;
      $display("FAIL %s sticky ff=%b idx=%0d mask=%b oerr=%b want %b %0d %b %b", name,
               first_fail_valid, first_fail_idx, first_fail_mask, order_err,
               m_ff_v, m_ff_idx, m_ff_mask, m_oerr);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 0;
  endtask

  task automatic load_basic();
    e0 = {34'h0d484321, 34'h0, 34'h0d800779f};
    e1 = {34'h0, 34'h3ffffffff, 34'h0};
    load_entry(0, 16'd3, e0, '1);
    load_entry(1, 16'd7, e1, '1);
    fill_obs();
    obs_seq[3] = e0;
    obs_seq[7] = e1;
  endtask

  task automatic test_basic_pass();
    int dk;
    load_basic();
    run_entries(2, 0, 1, "basic_pass", dk);
    checks++;
    if (dk != 8 || pass_cnt !== 2 || fail_cnt !== 0) begin
      errors++;
      $display("FAIL basic_pass const: done_cycle=%0d pass=%0d fail=%0d want 8 2 0", dk, pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_channel_fail();
    int dk;
    logic [TW-1:0] one;
    load_basic();
    one = 1;
    obs_seq[3] = e0 ^ (one << (2 * W));
    run_entries(2, 0, 0, "channel_fail", dk);
    checks++;
    if (first_fail_idx !== 0 || first_fail_mask !== 3'b100 || fail_cnt !== 1) begin
      errors++;
      $display("FAIL channel_fail const: ff_idx=%0d ff_mask=%b fail=%0d want 0 100 1",
               first_fail_idx, first_fail_mask, fail_cnt);
    end
  endtask

  task automatic test_masking();
    int dk;
    logic [TW-1:0] a, b, one;
    one = 1;
    a = rand_vec(); b = rand_vec();
    load_entry(0, 16'd2, a, ~one);
    load_entry(1, 16'd4, b, '0);
    fill_obs();
    obs_seq[2] = a ^ one;
    run_entries(2, 0, 0, "masking", dk);
    checks++;
    if (pass_cnt !== 2 || fail_cnt !== 0) begin
      errors++;
      $display("FAIL masking const: pass=%0d fail=%0d want 2 0", pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_order_err();
    int dk;
    logic [TW-1:0] a;
    a = rand_vec();
    load_entry(0, 16'd5, a, '1);
    load_entry(1, 16'd5, rand_vec(), '1);
    fill_obs();
    obs_seq[5] = a;
    run_entries(2, 0, 0, "order_err", dk);
    checks++;
    if (dk != 7 || order_err !== 1'b1 || first_fail_idx !== 1 || first_fail_mask !== 3'b111 ||
        pass_cnt !== 1 || fail_cnt !== 1) begin
      errors++;
      $display("FAIL order_err const: done_cycle=%0d oerr=%b ff_idx=%0d ff_mask=%b pass=%0d fail=%0d",
               dk, order_err, first_fail_idx, first_fail_mask, pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int dk;
    logic [TW-1:0] v [3];
    for (int i = 0; i < 3; i++) v[i] = rand_vec();
    load_entry(0, 16'd10, v[0], '1);
    load_entry(1, 16'd11, v[1], '1);
    load_entry(2, 16'd40, rand_vec(), '1);
    // entry 2 is rewritten in the same cycle as start
    m_stamp[2] = 16'd12; m_exp[2] = v[2]; m_mask[2] = '1;
    fill_obs();
    for (int i = 0; i < 3; i++) obs_seq[10 + i] = v[i];
    run_entries(3, 1, 0, "back_to_back", dk);
    checks++;
    if (dk != 13 || pass_cnt !== 3) begin
      errors++;
      $display("FAIL back_to_back const: done_cycle=%0d pass=%0d want 13 3", dk, pass_cnt);
    end
  endtask

  task automatic test_zero_entries();
    int dk;
    run_entries(0, 0, 0, "zero_entries", dk);
    checks++;
    if (dk != 0 || pass_cnt !== 0 || fail_cnt !== 0) begin
      errors++;
      $display("FAIL zero_entries const: done_cycle=%0d pass=%0d fail=%0d want 0 0 0", dk, pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    int dk;
    load_basic();
    @(negedge clk);
    start = 1; n_entries = CNTW'(2);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      start = 0;
      obs = obs_seq[k];
    end
    rst = 1;
    @(negedge clk);
    check_zero("midrun_reset_a");
    @(negedge clk);
    check_zero("midrun_reset_b");
    rst = 0;
    run_entries(2, 0, 0, "rerun_after_reset", dk);
    checks++;
    if (dk != 8 || pass_cnt !== 2 || fail_cnt !== 0) begin
      errors++;
      $display("FAIL rerun_after_reset const: done_cycle=%0d pass=%0d fail=%0d want 8 2 0",
               dk, pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_random();
    int dk, n, s;
    logic [TW-1:0] flip, one;
    one = 1;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, DEPTH);
      s = $urandom_range(0, 3);
      fill_obs();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) s = (s > 4) ? s - $urandom_range(1, 4) : s;
        else s = s + $urandom_range(0, 3);
        case ($urandom_range(0, 3))
          0: load_entry(i, CW'(s), rand_vec(), '0);
          1: load_entry(i, CW'(s), rand_vec(), '1);
          default: load_entry(i, CW'(s), rand_vec(), rand_vec());
        endcase
        flip = ($urandom_range(0, 2) == 0) ? (one << $urandom_range(0, TW - 1)) : '0;
        obs_seq[s] = m_exp[i] ^ flip;
      end
      run_entries(n, 0, it[0], "random", dk);
    end
  endtask

  initial begin
    rst = 0; load_we = 0; load_addr = '0; load_stamp = '0; load_exp = '0; load_mask = '0;
    n_entries = '0; start = 0; obs = '0;
    test_reset();
    test_basic_pass();
    test_channel_fail();
    test_masking();
    test_order_err();
    test_back_to_back();
    test_zero_entries();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/pipe_trace_checker.md
# pipe_trace_checker

Synthesisable, parametrised checker for multicycle and pipelined core debug taps. It stores up to DEPTH expected-value entries, each tagged with a cycle stamp. After `start`, it compares NCH observed channels (fetch, decode, mem, ...) against the stored entries at the stamped cycles under per-bit masks. It keeps pass/fail counts and captures the first failure. It sits beside the core top and lets regression checking run on hardware or in gate-level simulation without bench-side tasks.

## Interface
- NCH, 3, number of observed channels
- W, 34, width of each channel in bits; narrower taps are zero-extended by the instantiator
- DEPTH, 16, number of expected-vector entries
- CW, 16, cycle-stamp and cycle-counter width
- IW, $clog2(DEPTH), entry index width; CNTW = $clog2(DEPTH+1)
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- load_we  in  1  entry write strobe; accepted in IDLE and DONE, ignored in RUN
- load_addr  in  IW  entry index to write
- load_stamp  in  CW  cycle stamp for the entry
- load_exp  in  NCH*W  expected values; channel c occupies bits [c*W +: W]
- load_mask  in  NCH*W  compare mask; 1 means the bit is compared
- n_entries  in  CNTW  number of entries to run, sampled at `start`
- start  in  1  begin run; accepted in IDLE and DONE, ignored in RUN
- obs  in  NCH*W  observed debug taps
- busy  out  1  high in RUN
- done  out  1  high in DONE
- chk_valid  out  1  one-cycle pulse per evaluated entry
- chk_pass  out  1  result of that entry
- chk_idx  out  IW  index of that entry
- chk_fail_mask  out  NCH  per-channel mismatch flags for that entry
- pass_cnt, fail_cnt  out  CNTW  run totals
- first_fail_valid  out  1  sticky; a failure has occurred in this run
- first_fail_idx  out  IW  entry index of the first failure
- first_fail_mask  out  NCH  channel flags of the first failure
- order_err  out  1  sticky; an entry's stamp was already passed

## Operation
- States are IDLE, RUN and DONE. Reset puts the block in IDLE and drives every output to 0. Entry memory is not reset and its contents survive `rst`.
- IDLE/DONE with `start`=1:
  - if n_entries==0, go to DONE and leave counts at 0;
  - otherwise latch n_entries, clear cycle_cnt, idx, pass_cnt, fail_cnt, first_fail_* and order_err, then go to RUN.
- RUN, each cycle:
  - Let k = cycle_cnt and S = stamp[idx].
  - If k == S, compare `(obs ^ exp[idx]) & mask[idx]` per channel. Channel c fails if any compared bit differs. The entry passes only if no channel fails.
  - If k > S, the stamp was missed. The entry is a fail with chk_fail_mask all ones, and order_err is set.
  - If k < S, no action.
  - An evaluated entry increments idx; the next entry can be evaluated no earlier than the following cycle.
  - cycle_cnt increments every RUN cycle and saturates at 2^CW-1.
- When entry n_entries-1 is evaluated, the state goes to DONE on the same edge. busy drops and done rises.
- A fully masked entry (mask=0) always passes.
- A `load_we` asserted together with `start` is written before the run latches, so the run sees the new entry.
- A `load_we` in RUN is dropped silently.
- first_fail_* are captured on the first failing entry only and hold until the next accepted `start` or `rst`.
- pass_cnt and fail_cnt never exceed n_entries.

## Timing
- RUN cycle k spans edges E_k to E_{k+1}, where E_0 is the edge that accepted `start`.
- `obs` for entry stamp S is sampled at edge E_{S+1}, i.e. it must hold the expected value during RUN cycle S.
- chk_valid, chk_pass, chk_idx, chk_fail_mask and the counters update at E_{S+1} and are visible during cycle S+1. Latency is one cycle.
- done rises in the cycle after the last chk_valid edge, i.e. simultaneously with that entry's chk_valid.
- Back-to-back stamps S and S+1 give chk_valid on two consecutive cycles.
- `rst` mid-run returns to IDLE at the next edge with all outputs 0. No partial chk_valid is emitted.

## Test plan
- NCH=3, W=34. Load entry0 (stamp 3, ch0=0xd800779f, all-ones mask) and entry1 (stamp 7, ch1=0x3ffffffff); drive matching obs in cycles 3 and 7 -> chk_valid during cycles 4 and 8 with chk_pass=1, pass_cnt=2, fail_cnt=0, done in cycle 8.
- Same load, but ch2 obs=0x0d484320 against expected 0x0d484321 in cycle 3 -> chk_pass=0, chk_fail_mask=3'b100, first_fail_idx=0, final fail_cnt=1.
- Entry with mask bit0=0 and obs differing only in bit0 -> pass. Entry with mask=0 and arbitrary obs -> pass.
- Stamps 5 then 5 -> entry1 evaluated in cycle 6 as a miss: fail, chk_fail_mask=3'b111, order_err=1.
- n_entries=0 with `start` -> DONE next cycle, counts 0, no chk_valid. `start` asserted during RUN -> ignored, counts unaffected.
- Assert `rst` at cycle 4 of a 2-entry run, then re-`start` without reloading -> identical results to the first test; memory retained, all outputs 0 during reset.
